// File: rtl/nbr_frame_tx.sv
// nbr_frame_tx: serialises a node's own colour plus N neighbour colours as a framed, slot-indexed valid/ready stream
//   clk, rst                     : clock, synchronous active-high reset
//   ld_valid / ld_ready          : load handshake; self_in and nbr_in captured on ld_valid && ld_ready
//   self_in [W], nbr_in [N*W]    : own colour (slot 0) and neighbour colours (slot k = nbr_in[k*W-1 -: W])
//   tx_valid / tx_ready          : output beat handshake
//   tx_data, tx_slot, tx_sof/eof : beat payload, slot index 0..N, first/last beat markers
//   busy, frame_cnt              : frame in progress, completed-frame count (wraps)
module nbr_frame_tx #(
    parameter int W = 2,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ld_valid,
    output logic           ld_ready,
    input  logic [W-1:0]   self_in,
    input  logic [N*W-1:0] nbr_in,
    output logic           tx_valid,
    input  logic           tx_ready,
    output logic [W-1:0]   tx_data,
    output logic [2:0]     tx_slot,
    output logic           tx_sof,
    output logic           tx_eof,
    output logic           busy,
    output logic [7:0]     frame_cnt
);
    typedef enum logic {IDLE, SEND} state_t;
    state_t               r_state, w_state_n;
    logic [(N+1)*W-1:0]   r_shadow, w_shadow_n;
    logic [W-1:0]         r_data, w_data_n;
    logic [2:0]           r_slot, w_slot_n, w_slot_inc;
    logic                 r_sof, w_sof_n, r_eof, w_eof_n;
    logic [7:0]           r_cnt, w_cnt_n;
    assign w_slot_inc = r_slot + 3'd1;
    always_comb begin
        w_state_n  = r_state;
        w_shadow_n = r_shadow;
        w_data_n   = r_data;
        w_slot_n   = r_slot;
        w_sof_n    = r_sof;
        w_eof_n    = r_eof;
        w_cnt_n    = r_cnt;
        if (r_state == IDLE) begin
            if (ld_valid) begin
                w_shadow_n = {nbr_in, self_in};
                w_data_n   = self_in;
                w_slot_n   = 3'd0;
                w_sof_n    = 1'b1;
                w_eof_n    = 1'b0;
                w_state_n  = SEND;
            end
        end else if (tx_ready) begin
            // tx_valid is always high in SEND, so tx_ready alone marks a transfer
            if (r_slot == 3'(N)) begin
                w_sof_n   = 1'b0;
                w_eof_n   = 1'b0;
                w_cnt_n   = r_cnt + 8'd1;
                w_state_n = IDLE;
            end else begin
                w_data_n = r_shadow[int'(w_slot_inc)*W +: W];
                w_slot_n = w_slot_inc;
                w_sof_n  = 1'b0;
                w_eof_n  = (w_slot_inc == 3'(N));
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_shadow <= '0;
            r_data   <= '0;
            r_slot   <= 3'd0;
            r_sof    <= 1'b0;
            r_eof    <= 1'b0;
            r_cnt    <= 8'd0;
        end else begin
            r_state  <= w_state_n;
            r_shadow <= w_shadow_n;
            r_data   <= w_data_n;
            r_slot   <= w_slot_n;
            r_sof    <= w_sof_n;
            r_eof    <= w_eof_n;
            r_cnt    <= w_cnt_n;
        end
    end
    // tx_valid, busy and ld_ready decode the state register directly, so they stay glitch-free registered outputs
    assign tx_valid  = (r_state == SEND);
    assign busy      = (r_state == SEND);
    assign ld_ready  = (r_state == IDLE);
    assign tx_data   = r_data;
    assign tx_slot   = r_slot;
    assign tx_sof    = r_sof;
    assign tx_eof    = r_eof;
    assign frame_cnt = r_cnt;
endmodule
